// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet source
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK,
    S_GAP
  } tx_state_t;

  localparam logic [1:0] ADDR_MAX  = 2'd2;
  // Feedback taps at bits 7,5,4,3 of the payload LFSR
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  function automatic logic cfg_legal(input logic [1:0] addr, input logic [5:0] len);
    return (addr <= ADDR_MAX) && (len != 6'd0);
  endfunction

endpackage

// File: rtl/router_pay_gen.sv
// rtl/router_pay_gen.sv - payload byte generator, incrementing counter or 8-bit LFSR
module router_pay_gen
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       mode,
  input  logic       advance,
  output logic [7:0] value,
  output logic [7:0] next_value
);

  logic lfsr_mode;

  always_comb begin
    if (lfsr_mode) begin
      next_value = {value[6:0], ^(value & LFSR_TAPS)};
    end else begin
      next_value = value + 8'd1;
    end
  end

  // An all-zero LFSR would lock up, so a zero seed starts it at 1
  always_ff @(posedge clock) begin
    if (!resetn) begin
      value     <= 8'h00;
      lfsr_mode <= 1'b0;
    end else if (load) begin
      value     <= (mode && (seed == 8'h00)) ? 8'h01 : seed;
      lfsr_mode <= mode;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - builds header/payload/parity packets for the router input port
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int CHK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pkt_len,
  input  logic       mode,
  input  logic [7:0] seed,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       pkt_err,
  output logic       cfg_err
);

  tx_state_t  state, state_n;
  logic [5:0] len_q, len_n;
  logic [5:0] byte_cnt, byte_cnt_n;
  logic [7:0] parity, parity_n;
  logic [7:0] chk_cnt, chk_cnt_n;
  logic [7:0] data_n;
  logic       valid_n, done_n, pkt_err_n, cfg_err_n;
  logic       pay_load, pay_advance;
  logic [7:0] pay_value, pay_next;
  hdr_t       start_hdr;

  assign start_hdr = '{len: pkt_len, addr: dest_addr};

  router_pay_gen u_pay_gen (
    .clock      (clock),
    .resetn     (resetn),
    .load       (pay_load),
    .seed       (seed),
    .mode       (mode),
    .advance    (pay_advance),
    .value      (pay_value),
    .next_value (pay_next)
  );

  // Outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    state_n     = state;
    len_n       = len_q;
    byte_cnt_n  = byte_cnt;
    parity_n    = parity;
    chk_cnt_n   = chk_cnt;
    data_n      = data_out;
    valid_n     = pkt_valid;
    done_n      = 1'b0;
    pkt_err_n   = pkt_err;
    cfg_err_n   = 1'b0;
    pay_load    = 1'b0;
    pay_advance = 1'b0;
    case (state)
      S_IDLE: begin
        data_n  = 8'h00;
        valid_n = 1'b0;
        if (start) begin
          if (cfg_legal(dest_addr, pkt_len)) begin
            state_n   = S_HEADER;
            len_n     = pkt_len;
            parity_n  = start_hdr;
            pkt_err_n = 1'b0;
            pay_load  = 1'b1;
            data_n    = start_hdr;
            valid_n   = 1'b1;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_n    = S_PAYLOAD;
          byte_cnt_n = 6'd1;
          data_n     = pay_value;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          parity_n    = parity ^ pay_value;
          pay_advance = 1'b1;
          if (byte_cnt == len_q) begin
            state_n = S_PARITY;
            data_n  = parity ^ pay_value;
            valid_n = 1'b0;
          end else begin
            byte_cnt_n = byte_cnt + 6'd1;
            data_n     = pay_next;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_n   = S_CHECK;
          data_n    = 8'h00;
          chk_cnt_n = 8'h00;
        end
      end
      S_CHECK: begin
        pkt_err_n = pkt_err | err;
        if (chk_cnt == 8'(CHK_CYCLES - 1)) begin
          state_n = S_GAP;
          done_n  = 1'b1;
        end else begin
          chk_cnt_n = chk_cnt + 8'd1;
        end
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      len_q     <= 6'd0;
      byte_cnt  <= 6'd0;
      parity    <= 8'h00;
      chk_cnt   <= 8'h00;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_busy   <= 1'b0;
      done      <= 1'b0;
      pkt_err   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      byte_cnt  <= byte_cnt_n;
      parity    <= parity_n;
      chk_cnt   <= chk_cnt_n;
      data_out  <= data_n;
      pkt_valid <= valid_n;
      tx_busy   <= (state_n != S_IDLE);
      done      <= done_n;
      pkt_err   <= pkt_err_n;
      cfg_err   <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

  localparam int CHK = 2;

  logic       clock = 1'b0;
  logic       resetn, start, mode, busy, err;
  logic [1:0] dest_addr;
  logic [5:0] pkt_len;
  logic [7:0] seed;
  logic [7:0] data_out;
  logic       pkt_valid, tx_busy, done, pkt_err, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_bytes [0:127];
  logic       exp_pkt_err = 1'b0;

  typedef struct {
    logic [1:0] a;
    logic [5:0] l;
    logic       m;
    logic [7:0] s;
    logic       exp_cfg;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  vec_t vecs [7];

  always #5 clock = ~clock;

  router_pkt_tx #(.CHK_CYCLES(CHK)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest_addr (dest_addr),
    .pkt_len   (pkt_len),
    .mode      (mode),
    .seed      (seed),
    .busy      (busy),
    .err       (err),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_busy   (tx_busy),
    .done      (done),
    .pkt_err   (pkt_err),
    .cfg_err   (cfg_err)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h, want %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference packet: header, len payload bytes, XOR of everything before it
  function automatic void build_model(input logic [1:0] a, input logic [5:0] l,
                                      input logic m, input logic [7:0] s);
    logic [7:0] v;
    logic [7:0] par;
    int         n;
    n = int'(l);
    exp_bytes[0] = {l, a};
    par = {l, a};
    v = (m && s == 8'h00) ? 8'h01 : s;
    for (int i = 1; i <= n; i++) begin
      exp_bytes[i] = v;
      par = par ^ v;
      v = m ? {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]} : v + 8'd1;
    end
    exp_bytes[n + 1] = par;
  endfunction

  task automatic run_packet(input logic [1:0] a, input logic [5:0] l, input logic m,
                            input logic [7:0] s, input logic [63:0] busy_pat,
                            input bit rand_busy, input logic [CHK-1:0] err_pat,
                            output logic [7:0] hdr_seen, output logic [7:0] par_seen);
    int   k, cyc, n;
    logic b, acc;
    n = int'(l);
    build_model(a, l, m, s);
    hdr_seen = 8'hxx;
    par_seen = 8'hxx;
    dest_addr = a; pkt_len = l; mode = m; seed = s; start = 1'b1;
    busy = 1'($urandom); err = 1'($urandom);
    @(negedge clock);
    start = 1'b0;
    dest_addr = 2'($urandom); pkt_len = 6'($urandom); mode = 1'($urandom); seed = 8'($urandom);
    k = 0;
    cyc = 0;
    while (k <= n + 1 && cyc < 1000) begin
      chk8("data_out", data_out, exp_bytes[k]);
      chk1("pkt_valid", pkt_valid, k <= n);
      chk1("tx_busy", tx_busy, 1'b1);
      chk1("done_early", done, 1'b0);
      chk1("pkt_err_clear", pkt_err, 1'b0);
      if (k == 0) hdr_seen = data_out;
      if (k == n + 1) par_seen = data_out;
      b = (cyc < 64 && busy_pat[cyc]) || (rand_busy && $urandom_range(0, 3) == 0);
      busy = b;
      err = 1'($urandom);
      @(negedge clock);
      if (!b) k++;
      cyc++;
    end
    if (cyc >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL packet_timeout: got %0d bytes, want %0d", k, n + 2);
    end
    acc = 1'b0;
    for (int j = 0; j < CHK; j++) begin
      chk1("check_done", done, 1'b0);
      chk1("check_valid", pkt_valid, 1'b0);
      chk8("check_data", data_out, 8'h00);
      chk1("check_tx_busy", tx_busy, 1'b1);
      err = err_pat[j];
      acc = acc | err_pat[j];
      busy = 1'($urandom);
      @(negedge clock);
    end
    chk1("done", done, 1'b1);
    chk1("pkt_err", pkt_err, acc);
    chk1("gap_tx_busy", tx_busy, 1'b1);
    err = 1'($urandom);
    busy = 1'($urandom);
    @(negedge clock);
    chk1("done_pulse", done, 1'b0);
    chk1("idle_tx_busy", tx_busy, 1'b0);
    chk1("pkt_err_hold", pkt_err, acc);
    chk8("idle_data", data_out, 8'h00);
    err = 1'b0;
    busy = 1'b0;
    exp_pkt_err = acc;
  endtask

  task automatic run_illegal(input logic [1:0] a, input logic [5:0] l, input logic m,
                             input logic [7:0] s);
    dest_addr = a; pkt_len = l; mode = m; seed = s; start = 1'b1;
    busy = 1'($urandom);
    @(negedge clock);
    start = 1'b0;
    chk1("cfg_err", cfg_err, 1'b1);
    chk1("cfg_valid", pkt_valid, 1'b0);
    chk1("cfg_tx_busy", tx_busy, 1'b0);
    chk1("cfg_pkt_err", pkt_err, exp_pkt_err);
    chk8("cfg_data", data_out, 8'h00);
    @(negedge clock);
    chk1("cfg_err_pulse", cfg_err, 1'b0);
    chk1("cfg_still_idle", tx_busy, 1'b0);
    chk1("cfg_valid_low", pkt_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h, p;
    logic [1:0] ra;
    logic [5:0] rl;

    vecs[0] = '{2'd1, 6'd3,  1'b0, 8'h10, 1'b0, 8'h0D, 8'h1E};
    vecs[1] = '{2'd2, 6'd2,  1'b1, 8'h00, 1'b0, 8'h0A, 8'h09};
    vecs[2] = '{2'd0, 6'd1,  1'b0, 8'hFF, 1'b0, 8'h04, 8'hFB};
    vecs[3] = '{2'd2, 6'd63, 1'b0, 8'h00, 1'b0, 8'hFE, 8'hC1};
    vecs[4] = '{2'd0, 6'd1,  1'b1, 8'h80, 1'b0, 8'h04, 8'h84};
    vecs[5] = '{2'd3, 6'd4,  1'b0, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{2'd1, 6'd0,  1'b0, 8'h00, 1'b1, 8'h00, 8'h00};

    resetn = 1'b0; start = 1'b0; dest_addr = 2'd0; pkt_len = 6'd0;
    mode = 1'b0; seed = 8'h00; busy = 1'b0; err = 1'b0;
    repeat (3) @(negedge clock);
    chk8("rst_data", data_out, 8'h00);
    chk1("rst_valid", pkt_valid, 1'b0);
    chk1("rst_tx_busy", tx_busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_pkt_err", pkt_err, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_cfg) begin
        run_illegal(vecs[i].a, vecs[i].l, vecs[i].m, vecs[i].s);
      end else begin
        run_packet(vecs[i].a, vecs[i].l, vecs[i].m, vecs[i].s, 64'd0, 1'b0, '0, h, p);
        chk8("tbl_header", h, vecs[i].exp_hdr);
        chk8("tbl_parity", p, vecs[i].exp_par);
      end
    end

    // Two stall cycles right after header acceptance
    run_packet(2'd1, 6'd3, 1'b0, 8'h10, 64'b110, 1'b0, '0, h, p);
    chk8("stall_header", h, 8'h0D);
    chk8("stall_parity", p, 8'h1E);

    // Router error during CHECK, held until the next legal start
    run_packet(2'd2, 6'd5, 1'b1, 8'h33, 64'd0, 1'b0, 2'b10, h, p);
    repeat (3) @(negedge clock);
    chk1("err_held", pkt_err, 1'b1);
    run_illegal(2'd3, 6'd7, 1'b0, 8'h00);
    run_packet(2'd0, 6'd2, 1'b0, 8'h40, 64'd0, 1'b0, '0, h, p);

    // Reset while the second payload byte is on the bus
    dest_addr = 2'd0; pkt_len = 6'd5; mode = 1'b0; seed = 8'h20; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk8("mid_byte2", data_out, 8'h21);
    resetn = 1'b0;
    err = 1'b1;
    @(negedge clock);
    chk8("mrst_data", data_out, 8'h00);
    chk1("mrst_valid", pkt_valid, 1'b0);
    chk1("mrst_tx_busy", tx_busy, 1'b0);
    chk1("mrst_done", done, 1'b0);
    chk1("mrst_pkt_err", pkt_err, 1'b0);
    chk1("mrst_cfg_err", cfg_err, 1'b0);
    resetn = 1'b1;
    err = 1'b0;
    @(negedge clock);
    chk1("mrst_idle", tx_busy, 1'b0);
    run_packet(2'd1, 6'd3, 1'b0, 8'h10, 64'd0, 1'b0, '0, h, p);
    chk8("post_rst_header", h, 8'h0D);
    chk8("post_rst_parity", p, 8'h1E);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          ra = 2'd3;
          rl = 6'($urandom);
        end else begin
          ra = 2'($urandom_range(0, 2));
          rl = 6'd0;
        end
        run_illegal(ra, rl, 1'($urandom), 8'($urandom));
      end else begin
        ra = 2'($urandom_range(0, 2));
        rl = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(1, 8)) : 6'($urandom_range(1, 63));
        run_packet(ra, rl, 1'($urandom), 8'($urandom), 64'd0, 1'b1, CHK'($urandom), h, p);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
